// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the bubble instruction and
// the fetch-entry record carried between fetch and decode.
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] ins;
   } fetch_entry_t;

endpackage : pipe_pkg

// File: rtl/ifid_buffer.sv
// Small circular FIFO decoupling instruction fetch from decode. Entries become
// visible one cycle after they are pushed; flush and reset empty the buffer.
module ifid_buffer
   import pipe_pkg::*;
#(
   parameter int              DEPTH = 2,
   parameter logic [XLEN-1:0] NOP   = NOP_INS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid,
   input  logic [XLEN-1:0]          if_pc,
   input  logic [XLEN-1:0]          if_ins,
   output logic                     if_ready,
   input  logic                     flush,
   input  logic                     id_ready,
   output logic                     id_valid,
   output logic [XLEN-1:0]          id_pc,
   output logic [XLEN-1:0]          id_ins,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] occupancy;
   logic          push;
   logic          pop;

   // Readiness depends only on occupancy, so a full buffer never bypasses.
   assign if_ready = (occupancy < CW'(DEPTH));
   assign id_valid = (occupancy != '0);
   assign push     = if_valid & if_ready;
   assign pop      = id_valid & id_ready;
   assign count    = occupancy;

   assign id_pc  = id_valid ? mem[head].pc  : '0;
   assign id_ins = id_valid ? mem[head].ins : NOP;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         case ({push, pop})
            2'b10:   occupancy <= occupancy + CW'(1);
            2'b01:   occupancy <= occupancy - CW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Storage is not cleared; stale entries are unreachable once pointers reset.
   always_ff @(posedge clk) begin
      if (!rst && !flush && push) begin
         mem[tail] <= '{pc: if_pc, ins: if_ins};
      end
   end

endmodule : ifid_buffer

// File: tb/tb_ifid_buffer.sv
// Self-checking bench for ifid_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based model of the fetch buffer.
module tb_ifid_buffer;
   import pipe_pkg::*;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_valid;
   logic [31:0]   if_pc;
   logic [31:0]   if_ins;
   logic          if_ready;
   logic          flush;
   logic          id_ready;
   logic          id_valid;
   logic [31:0]   id_pc;
   logic [31:0]   id_ins;
   logic [CW-1:0] count;

   logic [63:0] model_q[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] next_pc;

   ifid_buffer #(.DEPTH(DEPTH), .NOP(32'h0000_0000)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_ins   (if_ins),
      .if_ready (if_ready),
      .flush    (flush),
      .id_ready (id_ready),
      .id_valid (id_valid),
      .id_pc    (id_pc),
      .id_ins   (id_ins),
      .count    (count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passed++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
   endtask

   // Compare every output against what the model says the buffer holds.
   task automatic checkAll(input string tag);
      logic [63:0] head_entry;
      head_entry = (model_q.size() != 0) ? model_q[0] : 64'h0;
      checkOutput({tag, ".count"},    32'(count),    32'(model_q.size()));
      checkOutput({tag, ".if_ready"}, 32'(if_ready), 32'(model_q.size() < DEPTH));
      checkOutput({tag, ".id_valid"}, 32'(id_valid), 32'(model_q.size() != 0));
      checkOutput({tag, ".id_pc"},    id_pc,         head_entry[63:32]);
      checkOutput({tag, ".id_ins"},   id_ins,
                  (model_q.size() != 0) ? head_entry[31:0] : 32'h0000_0000);
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic applyStimulus(input string tag, input logic r, input logic f,
                                input logic v, input logic [31:0] pc,
                                input logic [31:0] ins, input logic dr);
      logic do_push;
      logic do_pop;
      rst      = r;
      flush    = f;
      if_valid = v;
      if_pc    = pc;
      if_ins   = ins;
      id_ready = dr;
      do_push  = v && (model_q.size() < DEPTH);
      do_pop   = dr && (model_q.size() != 0);
      @(posedge clk);
      if (r || f) begin
         model_q.delete();
      end else begin
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back({pc, ins});
      end
      #1;
      checkAll(tag);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_ins = '0; id_ready = 1'b0;

      applyStimulus("reset", 1, 0, 0, 32'h0, 32'h0, 0);

      applyStimulus("push1", 0, 0, 1, 32'h3000, 32'h8C08_0000, 0);
      applyStimulus("push2", 0, 0, 1, 32'h3004, 32'h8C08_0004, 0);
      applyStimulus("full_hold", 0, 0, 1, 32'h3008, 32'h8C08_0008, 0);
      applyStimulus("full_pop", 0, 0, 1, 32'h3008, 32'h8C08_0008, 1);
      applyStimulus("drain1", 0, 0, 0, 32'h0, 32'h0, 1);
      applyStimulus("push_pop", 0, 0, 1, 32'h300C, 32'h8C08_000C, 1);

      applyStimulus("fill", 0, 0, 1, 32'h3010, 32'h8C08_0010, 0);
      applyStimulus("flush", 0, 1, 1, 32'h3014, 32'h8C08_0014, 1);
      applyStimulus("flush_empty", 0, 1, 0, 32'h0, 32'h0, 1);

      for (int i = 0; i < 11; i++) begin
         applyStimulus("stream", 0, 0, (i < 10), 32'h3000 + 32'(4 * i),
                       32'h8C08_0000 + 32'(i), 1);
      end

      applyStimulus("refill1", 0, 0, 1, 32'h4000, 32'h1111_1111, 0);
      applyStimulus("refill2", 0, 0, 1, 32'h4004, 32'h2222_2222, 0);
      applyStimulus("rst_full", 1, 1, 1, 32'h4008, 32'h3333_3333, 1);

      next_pc = 32'h5000;
      for (int i = 0; i < 400; i++) begin
         logic r, f, v, dr;
         r  = ($urandom_range(0, 63) == 0);
         f  = ($urandom_range(0, 15) == 0);
         v  = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 1) == 1);
         applyStimulus("random", r, f, v, next_pc, $urandom, dr);
         next_pc = next_pc + 32'd4;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_ifid_buffer
